alarm_ring_sequencer: RTL and testbench
=======================================

// Module: alarm_ring_sequencer
// PURPOSE
//   Sequences the alarm once it fires: buzzer cadence, snooze cycles, auto-timeout and dismiss.
//   Sits between the alarm-match compare and the buzzer driver; replaces a bare level "alarm on".
//   Moore FSM: all outputs decode from registered state/counters; no combinational input->output path.
// PARAMETERS
//   BEEP_ON_CYC       4    clk cycles buzzer high per cadence period (>=1)
//   BEEP_OFF_CYC      4    clk cycles buzzer low per cadence period (>=1)
//   SNOOZE_SEC        540  i_Sec_Tick pulses spent in SNOOZE before re-ring (1..65535)
//   RING_TIMEOUT_SEC  300  i_Sec_Tick pulses spent in RING before auto-stop (1..65535)
//   MAX_SNOOZES       3    snoozes allowed per alarm event (0..15)
// PORTS
//   Clocking: one clock; reset is synchronous and active-high.
//   i_Clk            in   1  system clock
//   i_Reset          in   1  synchronous active-high reset
//   i_Sec_Tick       in   1  one-cycle pulse per second
//   i_Alarm_Enable   in   1  alarm armed (level)
//   i_Alarm_Match    in   1  current time == alarm time (level, held for the whole minute)
//   i_Snooze         in   1  debounced snooze button (level)
//   i_Dismiss        in   1  debounced dismiss button (level)
//   o_Buzzer         out  1  buzzer drive
//   o_Ringing        out  1  state == RING
//   o_Snoozing       out  1  state == SNOOZE
//   o_Snooze_Count   out  4  snoozes used in current alarm event
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; sec counter, cadence counter, snooze count, snooze_prev = 0.
//   Snooze edge: snz_rise = i_Snooze & ~snooze_prev; snooze_prev registers i_Snooze every cycle.
//   States: IDLE, RING, SNOOZE, DONE. Latency: input sampled at edge N -> new state visible after N.
//   IDLE:   i_Alarm_Enable & i_Alarm_Match -> RING; snooze count := 0.
//   RING (priority high->low):
//     ~i_Alarm_Enable | i_Dismiss                   -> DONE
//     snz_rise & count < MAX_SNOOZES                -> SNOOZE; count += 1
//     snz_rise & count == MAX_SNOOZES               -> ignored (stay RING)
//     i_Sec_Tick & sec_cnt == RING_TIMEOUT_SEC-1    -> DONE
//   SNOOZE (priority): ~i_Alarm_Enable | i_Dismiss -> DONE;
//     i_Sec_Tick & sec_cnt == SNOOZE_SEC-1 -> RING.
//   DONE:   ~i_Alarm_Match -> IDLE (blocks re-trigger within same match minute).
//   sec_cnt: 16 bit; cleared on every entry to RING or SNOOZE; +1 per i_Sec_Tick while in RING/SNOOZE;
//     a tick in the entry cycle is not counted. Exactly N ticks elapse before expiry.
//   Cadence: cad_cnt counts 0..BEEP_ON_CYC+BEEP_OFF_CYC-1 and wraps, only in RING; cleared on RING entry.
//     o_Buzzer = (state==RING) & (cad_cnt < BEEP_ON_CYC): high in first RING cycle.
//   o_Snooze_Count holds through SNOOZE/RING/DONE/IDLE; cleared only on IDLE->RING or reset.
//   Reset mid-RING/SNOOZE: all outputs 0 the cycle after reset sampled; no residual buzzer.
// TESTING  (BEEP_ON=2, BEEP_OFF=3, SNOOZE_SEC=3, RING_TIMEOUT_SEC=5, MAX_SNOOZES=2)
//   Enable=1, match high at edge 10 -> o_Ringing=1 from cycle 11; o_Buzzer 1,1,0,0,0 repeating.
//   Snooze pulse in RING -> o_Snoozing=1, o_Buzzer=0, count=1; 3rd tick -> RING, buzzer high 1st cycle.
//   Count=2, snooze pressed -> stays RING; 5th tick -> DONE; match held -> stays; match low -> IDLE.
//   Dismiss+snooze same cycle in RING -> DONE, count unchanged; enable low in SNOOZE -> DONE next cycle.
//   Enable=0, match=1 -> remains IDLE, all outputs 0.
//   Reset during SNOOZE with count=1 -> next cycle IDLE, o_Snooze_Count=0, all outputs 0.

Source files
------------

// File: rtl/alarm_ring_sequencer.sv
// ---------------------------------------------------------------------------
// alarm_ring_sequencer
//
// Sequences the alarm once the time/alarm compare fires. It produces the
// buzzer on/off cadence, handles snooze cycles with a per-event snooze limit,
// auto-stops after a ring timeout, and accepts a dismiss. In the datapath it
// sits between the alarm-match compare and the buzzer driver.
//
// This is a Moore machine. Every output decodes only from registered state
// and counters, so there is no combinational path from any input to any
// output. An input sampled at clock edge N shows up in the outputs just
// after edge N.
//
// Ports
//   i_Clk           : system clock
//   i_Reset         : synchronous, active-high reset
//   i_Sec_Tick      : one-cycle pulse per second
//   i_Alarm_Enable  : alarm armed (level)
//   i_Alarm_Match   : current time equals alarm time (level, held for the minute)
//   i_Snooze        : debounced snooze button (level; acts on its rising edge)
//   i_Dismiss       : debounced dismiss button (level)
//   o_Buzzer        : buzzer drive
//   o_Ringing       : high while in RING
//   o_Snoozing      : high while in SNOOZE
//   o_Snooze_Count  : snoozes used in the current alarm event
// ---------------------------------------------------------------------------
module alarm_ring_sequencer #(
  parameter int unsigned BEEP_ON_CYC      = 4,
  parameter int unsigned BEEP_OFF_CYC     = 4,
  parameter int unsigned SNOOZE_SEC       = 540,
  parameter int unsigned RING_TIMEOUT_SEC = 300,
  parameter int unsigned MAX_SNOOZES      = 3
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Sec_Tick,
  input  logic       i_Alarm_Enable,
  input  logic       i_Alarm_Match,
  input  logic       i_Snooze,
  input  logic       i_Dismiss,
  output logic       o_Buzzer,
  output logic       o_Ringing,
  output logic       o_Snoozing,
  output logic [3:0] o_Snooze_Count
);

  // The cadence period is at least 2 cycles, so CAD_W is always at least 1.
  localparam int unsigned CAD_PERIOD = BEEP_ON_CYC + BEEP_OFF_CYC;
  localparam int unsigned CAD_W      = $clog2(CAD_PERIOD);

  localparam logic [CAD_W-1:0] CAD_LAST   = CAD_W'(CAD_PERIOD - 1);
  localparam logic [CAD_W-1:0] CAD_ON     = CAD_W'(BEEP_ON_CYC);
  localparam logic [15:0]      RING_LAST  = 16'(RING_TIMEOUT_SEC - 1);
  localparam logic [15:0]      SNZ_LAST   = 16'(SNOOZE_SEC - 1);
  localparam logic [3:0]       MAX_SNZ    = 4'(MAX_SNOOZES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      sec_cnt_q, sec_cnt_d;
  logic [CAD_W-1:0] cad_cnt_q, cad_cnt_d;
  logic [3:0]       snz_cnt_q, snz_cnt_d;
  logic             snooze_prev_q;
  logic             snz_rise;
  logic             stop_req;

  assign snz_rise = i_Snooze & ~snooze_prev_q;
  assign stop_req = ~i_Alarm_Enable | i_Dismiss;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= ST_IDLE;
      sec_cnt_q     <= '0;
      cad_cnt_q     <= '0;
      snz_cnt_q     <= '0;
      snooze_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sec_cnt_q     <= sec_cnt_d;
      cad_cnt_q     <= cad_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      snooze_prev_q <= i_Snooze;
    end
  end

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    cad_cnt_d = cad_cnt_q;
    snz_cnt_d = snz_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_Alarm_Enable && i_Alarm_Match) begin
          // A new alarm event starts with a fresh snooze budget.
          state_d   = ST_RING;
          snz_cnt_d = '0;
          sec_cnt_d = '0;
          cad_cnt_d = '0;
        end
      end

      ST_RING: begin
        cad_cnt_d = (cad_cnt_q == CAD_LAST) ? '0 : cad_cnt_q + 1'b1;
        if (stop_req) begin
          state_d = ST_DONE;
        end else if (snz_rise && (snz_cnt_q < MAX_SNZ)) begin
          state_d   = ST_SNOOZE;
          snz_cnt_d = snz_cnt_q + 4'd1;
          sec_cnt_d = '0;
        end else if (i_Sec_Tick) begin
          // A snooze press with the budget exhausted has no effect, so the
          // timeout still runs in the same cycle.
          if (sec_cnt_q == RING_LAST) begin
            state_d = ST_DONE;
          end else begin
            sec_cnt_d = sec_cnt_q + 16'd1;
          end
        end
      end

      ST_SNOOZE: begin
        if (stop_req) begin
          state_d = ST_DONE;
        end else if (i_Sec_Tick) begin
          if (sec_cnt_q == SNZ_LAST) begin
            // Re-ring: restart the timeout and begin the cadence in its on phase.
            state_d   = ST_RING;
            sec_cnt_d = '0;
            cad_cnt_d = '0;
          end else begin
            sec_cnt_d = sec_cnt_q + 16'd1;
          end
        end
      end

      ST_DONE: begin
        // Wait out the match minute so the same match cannot retrigger.
        if (!i_Alarm_Match) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_Ringing      = (state_q == ST_RING);
  assign o_Snoozing     = (state_q == ST_SNOOZE);
  assign o_Buzzer       = (state_q == ST_RING) && (cad_cnt_q < CAD_ON);
  assign o_Snooze_Count = snz_cnt_q;

endmodule

// File: tb/tb_alarm_ring_sequencer.sv
module tb_alarm_ring_sequencer;

  logic       clk = 1'b0;
  logic       rst, tick, en, match, snz, dis;
  logic       buz, ring, snzing;
  logic [3:0] scnt;

  int checks = 0;
  int errors = 0;

  alarm_ring_sequencer #(
    .BEEP_ON_CYC     (2),
    .BEEP_OFF_CYC    (3),
    .SNOOZE_SEC      (3),
    .RING_TIMEOUT_SEC(5),
    .MAX_SNOOZES     (2)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Sec_Tick    (tick),
    .i_Alarm_Enable(en),
    .i_Alarm_Match (match),
    .i_Snooze      (snz),
    .i_Dismiss     (dis),
    .o_Buzzer      (buz),
    .o_Ringing     (ring),
    .o_Snoozing    (snzing),
    .o_Snooze_Count(scnt)
  );

  always #5 clk = ~clk;

  // One active edge; inputs set before the call are sampled at that edge, and
  // outputs are read 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs as one word {buzzer, ringing, snoozing} plus the snooze count.
  task automatic chk_all(input string tag, input logic [2:0] exp_bits, input logic [3:0] exp_cnt);
    chk({tag, "_bits"}, {1'b0, buz, ring, snzing}, {1'b0, exp_bits});
    chk({tag, "_cnt"}, scnt, exp_cnt);
  endtask

  task automatic sec_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic snooze_press();
    snz = 1'b1;
    step();
    snz = 1'b0;
  endtask

  logic [4:0] cad_pat;

  initial begin
    rst = 1'b1; tick = 1'b0; en = 1'b0; match = 1'b0; snz = 1'b0; dis = 1'b0;
    cad_pat = 5'b00011; // bit i = expected buzzer at cadence position i
    step(); step();
    chk_all("reset", 3'b000, 4'd0);

    rst = 1'b0; en = 1'b1;
    step();
    chk_all("idle_nomatch", 3'b000, 4'd0);

    // Match -> RING with buzzer high on the first cycle, cadence 1,1,0,0,0.
    match = 1'b1;
    step();
    chk_all("ring_entry", 3'b110, 4'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("cadence", {3'b0, buz}, {3'b0, cad_pat[i % 5]});
      chk("cad_ring", {3'b0, ring}, 4'd1);
    end

    // First snooze.
    snooze_press();
    chk_all("snooze1", 3'b001, 4'd1);
    sec_tick();
    chk_all("snz1_t1", 3'b001, 4'd1);
    step();
    sec_tick();
    chk_all("snz1_t2", 3'b001, 4'd1);
    sec_tick();
    chk_all("rering1", 3'b110, 4'd1);

    // Second snooze uses up the budget.
    snooze_press();
    chk_all("snooze2", 3'b001, 4'd2);
    sec_tick(); sec_tick();
    chk_all("snz2_t2", 3'b001, 4'd2);
    sec_tick();
    chk_all("rering2", 3'b110, 4'd2);

    // Further presses are ignored; a held button is not a new press.
    snz = 1'b1;
    step();
    chk("snz_ignored_ring", {3'b0, ring}, 4'd1);
    chk("snz_ignored_cnt", scnt, 4'd2);
    step();
    chk("snz_held_ring", {3'b0, ring}, 4'd1);
    snz = 1'b0;

    // Timeout after exactly 5 ticks.
    for (int i = 1; i <= 4; i++) begin
      sec_tick();
      chk("timeout_pending", {3'b0, ring}, 4'd1);
    end
    sec_tick();
    chk_all("timeout_done", 3'b000, 4'd2);

    // Match still high: stays in DONE, no retrigger.
    step(); step();
    chk_all("done_hold", 3'b000, 4'd2);

    // Match low -> IDLE, count is held.
    match = 1'b0;
    step();
    chk_all("idle_after_done", 3'b000, 4'd2);

    // New event clears the count.
    match = 1'b1;
    step();
    chk_all("ring_again", 3'b110, 4'd0);

    // Dismiss wins over a simultaneous snooze press.
    dis = 1'b1; snz = 1'b1;
    step();
    chk_all("dismiss_snz", 3'b000, 4'd0);
    dis = 1'b0; snz = 1'b0;

    match = 1'b0;
    step();
    match = 1'b1;
    step();
    chk_all("ring3", 3'b110, 4'd0);
    snooze_press();
    chk_all("snooze3", 3'b001, 4'd1);

    // Enable dropped during SNOOZE -> DONE.
    en = 1'b0;
    step();
    chk_all("en_low_snz", 3'b000, 4'd1);

    // Disabled alarm ignores a match.
    match = 1'b0;
    step();
    match = 1'b1;
    step(); step();
    chk_all("disabled_match", 3'b000, 4'd1);

    // Reset in SNOOZE with count 1.
    en = 1'b1;
    step();
    chk_all("ring4", 3'b110, 4'd0);
    snooze_press();
    chk_all("snooze4", 3'b001, 4'd1);
    rst = 1'b1; match = 1'b0;
    step();
    chk_all("reset_in_snz", 3'b000, 4'd0);
    rst = 1'b0;
    step();
    chk_all("post_reset_idle", 3'b000, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
